// File: rtl/input_conditioner.sv
// Synchronizes an asynchronous pin, debounces it, and reports clean edges
// as single-cycle pulses plus a wrapping rising-edge count.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 count_clr,
  output logic                 sig_sync,
  output logic                 sig_clean,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_count
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       deb_q, deb_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    deb_d   = deb_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    // Any sample agreeing with the clean level restarts the run.
    if (sync_q[SYNC_STAGES-1] == clean_q) begin
      deb_d = '0;
    end else if (deb_q == DEB_LAST) begin
      deb_d   = '0;
      clean_d = sync_q[SYNC_STAGES-1];
      rise_d  = sync_q[SYNC_STAGES-1];
      fall_d  = ~sync_q[SYNC_STAGES-1];
    end else begin
      deb_d = deb_q + DEB_W'(1);
    end

    // A clear coinciding with a registered rise still counts that rise.
    cnt_d = cnt_q;
    if (count_clr && rise_q) begin
      cnt_d = CNT_WIDTH'(1);
    end else if (count_clr) begin
      cnt_d = '0;
    end else if (rise_q) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q  <= '0;
      deb_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sig_sync   = sync_q[SYNC_STAGES-1];
  assign sig_clean  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign edge_count = cnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected edge pulses (kind + cycle) per DUT,
// a negedge monitor pops and compares whenever a DUT raises a pulse.
module tb_input_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;
  logic sig_a, clr_a, sync_a, clean_a, rise_a, fall_a;
  logic [7:0] cnt_a;
  logic sig_b, clr_b, sync_b, clean_b, rise_b, fall_b;
  logic [2:0] cnt_b;
  logic sig_c, clr_c, sync_c, clean_c, rise_c, fall_c;
  logic [7:0] cnt_c;

  input_conditioner dut_a (
    .clk_in(clk), .rst(rst), .sig_in(sig_a), .count_clr(clr_a),
    .sig_sync(sync_a), .sig_clean(clean_a), .rise_pulse(rise_a),
    .fall_pulse(fall_a), .edge_count(cnt_a));

  input_conditioner #(.CNT_WIDTH(3)) dut_b (
    .clk_in(clk), .rst(rst), .sig_in(sig_b), .count_clr(clr_b),
    .sig_sync(sync_b), .sig_clean(clean_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .edge_count(cnt_b));

  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_c (
    .clk_in(clk), .rst(rst), .sig_in(sig_c), .count_clr(clr_c),
    .sig_sync(sync_c), .sig_clean(clean_c), .rise_pulse(rise_c),
    .fall_pulse(fall_c), .edge_count(cnt_c));

  typedef struct {
    bit rise;
    int cyc;
  } pulse_t;

  pulse_t exp_q[3][$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic push(int id, bit rise, int at);
    pulse_t e;
    e.rise = rise;
    e.cyc  = at;
    exp_q[id].push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(int id, logic r, logic f);
    pulse_t e;
    if (r === 1'b1 || f === 1'b1) begin
      n_cmp++;
      if (r && f) begin
        n_fail++;
        $display("FAIL pulse[%0d]: rise and fall both high at cyc %0d", id, cyc);
      end else if (exp_q[id].size() == 0) begin
        n_fail++;
        $display("FAIL pulse[%0d]: unexpected rise=%0b fall=%0b at cyc %0d, none expected",
                 id, r, f, cyc);
      end else begin
        e = exp_q[id].pop_front();
        if (e.rise != r || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL pulse[%0d]: got rise=%0b at cyc %0d, expected rise=%0b at cyc %0d",
                   id, r, cyc, e.rise, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rise_a, fall_a);
    mon(1, rise_b, fall_b);
    mon(2, rise_c, fall_c);
  end

  task automatic ticks(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Default DUT: a level change driven now shows on sig_clean 2+4 edges later.
  task automatic drive_a(bit v);
    sig_a = v;
    push(0, v, cyc + 6);
  endtask

  int exp_wrap[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

  initial begin
    bit lvl;
    int hold;
    rst = 1'b1;
    sig_a = 1'b1; clr_a = 1'b0;
    sig_b = 1'b0; clr_b = 1'b0;
    sig_c = 1'b0; clr_c = 1'b0;

    // Reset with the pin held high
    ticks(3);
    chk("rst_sync",  sync_a,  0);
    chk("rst_clean", clean_a, 0);
    chk("rst_rise",  rise_a,  0);
    chk("rst_fall",  fall_a,  0);
    chk("rst_count", cnt_a,   0);
    rst = 1'b0;
    push(0, 1'b1, cyc + 6);
    ticks(5);
    chk("rel_clean_early", clean_a, 0);
    ticks(1);
    chk("rel_clean", clean_a, 1);
    chk("rel_rise",  rise_a,  1);
    ticks(1);
    chk("rel_rise_width", rise_a, 0);
    chk("rel_count", cnt_a, 1);

    // Clean step: fall, then rise
    drive_a(1'b0);
    ticks(1);
    chk("step_sync_hold", sync_a, 1);
    ticks(1);
    chk("step_sync_fall", sync_a, 0);
    ticks(7);
    drive_a(1'b1);
    ticks(1);
    chk("step_sync_lo", sync_a, 0);
    ticks(1);
    chk("step_sync_hi", sync_a, 1);
    ticks(8);
    chk("step_count", cnt_a, 2);

    // Single-sample dropout while clean is high: ignored
    sig_a = 1'b0;
    ticks(1);
    sig_a = 1'b1;
    ticks(8);
    chk("dropout_clean", clean_a, 1);

    // Glitch reject: 3 high, 1 low, then high
    drive_a(1'b0);
    ticks(8);
    sig_a = 1'b1;
    ticks(3);
    sig_a = 1'b0;
    ticks(1);
    drive_a(1'b1);
    ticks(5);
    chk("glitch_clean_wait", clean_a, 0);
    ticks(3);
    chk("glitch_count", cnt_a, 3);

    // Clear colliding with a rise, then clear alone
    drive_a(1'b0);
    ticks(8);
    drive_a(1'b1);
    ticks(6);
    chk("coll_rise", rise_a, 1);
    clr_a = 1'b1;
    ticks(1);
    clr_a = 1'b0;
    chk("coll_count", cnt_a, 1);
    ticks(2);
    clr_a = 1'b1;
    ticks(1);
    clr_a = 1'b0;
    chk("clr_count", cnt_a, 0);

    // Wrap with a 3-bit counter
    for (int i = 0; i < 9; i++) begin
      sig_b = 1'b1;
      push(1, 1'b1, cyc + 6);
      ticks(7);
      chk($sformatf("wrap_%0d", i), cnt_b, exp_wrap[i]);
      sig_b = 1'b0;
      push(1, 1'b0, cyc + 6);
      ticks(7);
    end

    // Three sync stages, single-sample debounce: 4-clock latency
    sig_c = 1'b1;
    push(2, 1'b1, cyc + 4);
    ticks(3);
    chk("p6_clean_early", clean_c, 0);
    ticks(1);
    chk("p6_clean", clean_c, 1);
    ticks(2);
    lvl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hold = $urandom_range(1, 4);
      lvl = ~lvl;
      sig_c = lvl;
      push(2, lvl, cyc + 4);
      ticks(hold);
    end
    ticks(8);

    for (int id = 0; id < 3; id++)
      chk($sformatf("pending_%0d", id), exp_q[id].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
